// File: rtl/pixel_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_feeder_if
//  Description : Stream bundle around the pixel feeder. Carries the 64-bit
//                input word stream from the DMA (s_t*) and the re-timed
//                pixel stream toward the conv engine (pixel_out*).
//                  master : DMA / engine side (drives s_t*, observes outputs)
//                  slave  : feeder side (consumes s_t*, drives s_tready and
//                           pixel_out*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pixel_feeder_if;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [63:0] pixel_out;
    logic        pixel_out_valid;
    logic        pixel_out_last;

    modport master (
        output s_tdata, s_tvalid, s_tlast,
        input  s_tready, pixel_out, pixel_out_valid, pixel_out_last
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast,
        output s_tready, pixel_out, pixel_out_valid, pixel_out_last
    );
endinterface
`default_nettype wire

// File: rtl/pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_feeder
//  Description : Re-times the unpadded DMA feature map into the conv
//                engine's pixel stream, inserting an optional one-pixel zero
//                border and generating the frame-final last flag.
//  Ports       : clk, rst_n (sync, active low)
//                cfg_img_width/height/ci_groups/pad - latched on go in IDLE
//                go        - start pulse, ignored while a frame is running
//                busy      - frame in flight
//                done      - one-cycle pulse with the last beat
//                err_tlast - sticky input tlast mismatch, cleared by go
//                bus       - input stream and engine pixel stream
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_feeder #(
    parameter int MAX_W = 1024,
    parameter int MAX_H = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   cfg_img_width,
    input  logic [15:0]   cfg_img_height,
    input  logic [9:0]    cfg_ci_groups,
    input  logic          cfg_pad,
    input  logic          go,
    output logic          busy,
    output logic          done,
    output logic          err_tlast,
    pixel_feeder_if.slave bus
);

    // Counters only need to span the padded maximum dimensions.
    localparam int c_COL_W = $clog2(MAX_W + 2);
    localparam int c_ROW_W = $clog2(MAX_H + 2);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    logic [16:0]          r_wp;
    logic [16:0]          r_hp;
    logic [9:0]           r_g;
    logic                 r_pad;
    logic [9:0]           r_ci;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [63:0]          r_pixel;
    logic                 r_valid;
    logic                 r_last;

    logic [16:0] w_col;
    logic [16:0] w_row;
    logic [16:0] w_wp_m1;
    logic [16:0] w_hp_m1;
    logic [16:0] w_wi_last;
    logic [16:0] w_hi_last;
    logic [9:0]  w_g_m1;
    logic        w_streaming;
    logic        w_border;
    logic        w_tready;
    logic        w_beat;
    logic        w_transfer;
    logic        w_ci_wrap;
    logic        w_col_wrap;
    logic        w_row_wrap;
    logic        w_final;
    logic        w_last_int;
    logic        w_zero_cfg;

    assign w_col       = 17'(r_col);
    assign w_row       = 17'(r_row);
    assign w_wp_m1     = r_wp - 17'd1;
    assign w_hp_m1     = r_hp - 17'd1;
    // Last interior column/row sit one position inside the border when padded.
    assign w_wi_last   = w_wp_m1 - {16'd0, r_pad};
    assign w_hi_last   = w_hp_m1 - {16'd0, r_pad};
    assign w_g_m1      = r_g - 10'd1;

    assign w_streaming = (r_state == ST_STREAM);
    assign w_border    = r_pad && ((w_row == 17'd0) || (w_row == w_hp_m1) ||
                                   (w_col == 17'd0) || (w_col == w_wp_m1));
    // Ready depends on state and counters only, never on s_tvalid.
    assign w_tready    = w_streaming && !w_border;
    assign w_transfer  = w_tready && bus.s_tvalid;
    // Border beats are emitted unconditionally; interior beats need input.
    assign w_beat      = w_streaming && (w_border || bus.s_tvalid);

    assign w_ci_wrap   = (r_ci == w_g_m1);
    assign w_col_wrap  = (w_col == w_wp_m1);
    assign w_row_wrap  = (w_row == w_hp_m1);
    assign w_final     = w_ci_wrap && w_col_wrap && w_row_wrap;
    assign w_last_int  = w_ci_wrap && (w_col == w_wi_last) && (w_row == w_hi_last);
    assign w_zero_cfg  = (cfg_img_width == 16'd0) || (cfg_img_height == 16'd0) ||
                         (cfg_ci_groups == 10'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wp    <= 17'd0;
            r_hp    <= 17'd0;
            r_g     <= 10'd0;
            r_pad   <= 1'b0;
            r_ci    <= 10'd0;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_pixel <= 64'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // busy drops one cycle after the last beat became visible.
                    r_busy <= 1'b0;
                    r_ci   <= 10'd0;
                    r_col  <= '0;
                    r_row  <= '0;
                    if (go) begin
                        r_wp  <= {1'b0, cfg_img_width}  + {15'd0, cfg_pad, 1'b0};
                        r_hp  <= {1'b0, cfg_img_height} + {15'd0, cfg_pad, 1'b0};
                        r_g   <= cfg_ci_groups;
                        r_pad <= cfg_pad;
                        r_err <= 1'b0;
                        if (w_zero_cfg) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_STREAM;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_beat) begin
                        r_valid <= 1'b1;
                        r_pixel <= w_border ? 64'd0 : bus.s_tdata;
                        if (w_transfer && (bus.s_tlast != w_last_int)) begin
                            r_err <= 1'b1;
                        end
                        if (w_final) begin
                            r_last  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                            r_ci    <= 10'd0;
                            r_col   <= '0;
                            r_row   <= '0;
                        end else if (w_ci_wrap) begin
                            r_ci <= 10'd0;
                            if (w_col_wrap) begin
                                r_col <= '0;
                                r_row <= r_row + c_ROW_W'(1);
                            end else begin
                                r_col <= r_col + c_COL_W'(1);
                            end
                        end else begin
                            r_ci <= r_ci + 10'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign err_tlast           = r_err;
    assign bus.s_tready        = w_tready;
    assign bus.pixel_out       = r_pixel;
    assign bus.pixel_out_valid = r_valid;
    assign bus.pixel_out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_pixel_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_feeder
//  Description : Scoreboard bench for pixel_feeder. Frames are described by
//                their geometry; a reference model walks the padded image
//                row-major and queues expected beats plus the input words.
//                A driver feeds the words with configurable valid gaps and a
//                monitor pops and compares every emitted beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_img_width = 16'd0;
    logic [15:0] cfg_img_height = 16'd0;
    logic [9:0]  cfg_ci_groups = 10'd0;
    logic        cfg_pad = 1'b0;
    logic        go = 1'b0;
    logic        busy;
    logic        done;
    logic        err_tlast;

    pixel_feeder_if bus ();

    pixel_feeder #(.MAX_W(1024), .MAX_H(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_img_width  (cfg_img_width),
        .cfg_img_height (cfg_img_height),
        .cfg_ci_groups  (cfg_ci_groups),
        .cfg_pad        (cfg_pad),
        .go             (go),
        .busy           (busy),
        .done           (done),
        .err_tlast      (err_tlast),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [64:0] exp_q[$];   // {last, data} expected on the engine side
    logic [64:0] in_q[$];    // {tlast, data} words still to be offered
    int          gap_mode = 0;
    int          beats_seen = 0;
    int          done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: walk padded rows, columns and channel groups.
    task automatic build_frame(input int w, input int h, input int g, input int pad,
                               input int dmode, input int err_kind, input int err_idx,
                               output int nbeats, output bit exp_err);
        int wp = w + 2 * pad;
        int hp = h + 2 * pad;
        int n  = w * h * g;
        int k  = 0;
        logic [63:0] d;
        bit fin, brd, tl;
        nbeats  = hp * wp * g;
        exp_err = (err_kind == 2) || (err_kind == 1 && err_idx != n - 1);
        for (int r = 0; r < hp; r++)
            for (int c = 0; c < wp; c++)
                for (int ci = 0; ci < g; ci++) begin
                    fin = (r == hp - 1) && (c == wp - 1) && (ci == g - 1);
                    brd = (pad != 0) && (r == 0 || r == hp - 1 || c == 0 || c == wp - 1);
                    if (brd) begin
                        exp_q.push_back({fin, 64'd0});
                    end else begin
                        case (dmode)
                            1:       d = 64'h11 * 64'(k + 1);
                            2:       d = 64'(k + 1);
                            default: d = {$urandom, $urandom};
                        endcase
                        tl = (k == n - 1);
                        if (err_kind == 1 && k == err_idx) tl = 1'b1;
                        if (err_kind == 2 && k == n - 1)   tl = 1'b0;
                        exp_q.push_back({fin, d});
                        in_q.push_back({tl, d});
                        k++;
                    end
                end
    endtask

    // Driver: inputs change on the falling edge; a transfer is known before
    // the rising edge because s_tready does not depend on s_tvalid.
    initial begin : p_driver
        bit fired = 1'b0;
        bit tog = 1'b0;
        bit want;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 64'd0;
        bus.s_tlast  = 1'b0;
        forever begin
            @(negedge clk);
            if (fired && in_q.size() > 0) in_q.delete(0);
            tog = ~tog;
            case (gap_mode)
                1:       want = tog;
                2:       want = ($urandom_range(0, 1) == 1);
                default: want = 1'b1;
            endcase
            if (want && in_q.size() > 0) begin
                bus.s_tvalid = 1'b1;
                {bus.s_tlast, bus.s_tdata} = in_q[0];
            end else begin
                bus.s_tvalid = 1'b0;
                bus.s_tlast  = 1'b0;
                bus.s_tdata  = {$urandom, $urandom};
            end
            fired = bus.s_tvalid && bus.s_tready;
        end
    end

    // Monitor: compare every emitted beat against the scoreboard.
    initial begin : p_monitor
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (bus.pixel_out_valid) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got %0h, expected no beat (t=%0t)",
                             bus.pixel_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", bus.pixel_out, e[63:0]);
                    check("beat_last", 64'(bus.pixel_out_last), 64'(e[64]));
                end
                check("busy_on_beat", 64'(busy), 64'd1);
            end
            if (bus.pixel_out_last) check("done_with_last", 64'(done), 64'd1);
            if (done) done_seen++;
        end
    end

    task automatic run_frame(input int w, input int h, input int g, input int pad,
                             input int dmode, input int gmode, input int err_kind,
                             input int err_idx, input bit midgo);
        int  nb;
        bit  ee;
        int  b0, d0;
        bit  got = 1'b0;
        build_frame(w, h, g, pad, dmode, err_kind, err_idx, nb, ee);
        gap_mode       = gmode;
        b0             = beats_seen;
        d0             = done_seen;
        cfg_img_width  = 16'(w);
        cfg_img_height = 16'(h);
        cfg_ci_groups  = 10'(g);
        cfg_pad        = pad[0];
        go             = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        check("busy_after_go", 64'(busy), 64'd1);
        check("err_clear_on_go", 64'(err_tlast), 64'd0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (midgo && cyc == 3) begin
                cfg_img_width = 16'd7;
                cfg_pad       = ~pad[0];
                go            = 1'b1;
            end else if (midgo && cyc == 4) begin
                go            = 1'b0;
                cfg_img_width = 16'(w);
                cfg_pad       = pad[0];
            end
            @(negedge clk); #1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done, expected done within budget");
        end else begin
            check("busy_on_done", 64'(busy), 64'd1);
            check("done_count", 64'(done_seen - d0), 64'd1);
            check("beat_count", 64'(beats_seen - b0), 64'(nb));
            check("err_tlast", 64'(err_tlast), 64'(ee));
            check("inputs_consumed", 64'(in_q.size()), 64'd0);
            check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        end
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic zero_frame(input int w, input int h, input int g);
        int b0 = beats_seen;
        cfg_img_width  = 16'(w);
        cfg_img_height = 16'(h);
        cfg_ci_groups  = 10'(g);
        cfg_pad        = 1'b1;
        go             = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("zero_no_beats", 64'(beats_seen - b0), 64'd0);
        check("zero_done_pulse", 64'(done), 64'd0);
    endtask

    initial begin : p_watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : p_main
        int w, h, g, pad, n, ek, ei, b0;
        bit got;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_tlast), 64'd0);
        check("rst_tready", 64'(bus.s_tready), 64'd0);
        check("rst_valid", 64'(bus.pixel_out_valid), 64'd0);
        check("rst_last", 64'(bus.pixel_out_last), 64'd0);
        check("rst_pixel", bus.pixel_out, 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        run_frame(2, 2, 1, 1, 1, 0, 0, 0, 1'b0);   // padded 2x2
        run_frame(3, 1, 3, 0, 2, 0, 0, 0, 1'b0);   // unpadded, G=3
        run_frame(2, 2, 1, 1, 1, 1, 0, 0, 1'b0);   // toggling valid
        run_frame(2, 2, 1, 0, 0, 0, 1, 1, 1'b0);   // early tlast on word 2
        run_frame(2, 2, 1, 0, 0, 0, 2, 0, 1'b0);   // missing final tlast
        run_frame(2, 2, 1, 1, 0, 2, 0, 0, 1'b1);   // go mid-frame ignored
        zero_frame(0, 3, 2);
        zero_frame(3, 0, 2);
        zero_frame(3, 3, 0);

        // Reset while beat 7 is on the outputs, then replay the frame.
        begin
            int nb;
            bit ee;
            build_frame(2, 2, 1, 1, 1, 0, 0, nb, ee);
            gap_mode       = 0;
            b0             = beats_seen;
            cfg_img_width  = 16'd2;
            cfg_img_height = 16'd2;
            cfg_ci_groups  = 10'd1;
            cfg_pad        = 1'b1;
            go             = 1'b1;
            @(negedge clk); #1;
            go  = 1'b0;
            got = 1'b0;
            for (int cyc = 0; cyc < 100; cyc++) begin
                if (beats_seen - b0 == 7) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk); #1;
            end
            check("reset_reach_beat7", 64'(got), 64'd1);
            rst_n = 1'b0;
            @(negedge clk); #1;
            check("midrst_valid", 64'(bus.pixel_out_valid), 64'd0);
            check("midrst_last", 64'(bus.pixel_out_last), 64'd0);
            check("midrst_pixel", bus.pixel_out, 64'd0);
            check("midrst_tready", 64'(bus.s_tready), 64'd0);
            check("midrst_busy", 64'(busy), 64'd0);
            check("midrst_done", 64'(done), 64'd0);
            rst_n = 1'b1;
            in_q.delete();
            exp_q.delete();
            @(negedge clk); #1;
            in_q.delete();
            exp_q.delete();
        end
        run_frame(2, 2, 1, 1, 1, 0, 0, 0, 1'b0);

        // Randomized frames, issued back-to-back on the done cycle.
        for (int i = 0; i < 10; i++) begin
            w   = $urandom_range(1, 5);
            h   = $urandom_range(1, 4);
            g   = $urandom_range(1, 3);
            pad = $urandom_range(0, 1);
            n   = w * h * g;
            ek  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            ei  = $urandom_range(0, n - 1);
            run_frame(w, h, g, pad, 0, $urandom_range(0, 2), ek, ei, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
